// File: rtl/perceptron_comm_ctrl.sv
// Host packet controller for the perceptron: parses opcodes, commits weight/input words
// atomically and serialises responses. Define COMM_RX_TIMEOUT_EN for the inter-byte timeout.
module perceptron_comm_ctrl #(
    parameter int fp_integer_width  = 4,
    parameter int fp_fract_width    = 12,
    parameter int rx_timeout_cycles = 120000
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     rx_new_value,
    input  logic [7:0]                               rx_data,
    input  logic                                     tx_busy,
    output logic                                     tx_start,
    output logic [7:0]                               tx_data,
    input  logic                                     result,
    output logic [fp_integer_width+fp_fract_width-1:0] weight1,
    output logic [fp_integer_width+fp_fract_width-1:0] weight2,
    output logic [fp_integer_width+fp_fract_width-1:0] input1,
    output logic [fp_integer_width+fp_fract_width-1:0] input2,
    output logic [4:0]                               cont_state
);

    if (fp_integer_width + fp_fract_width != 16 || rx_timeout_cycles < 1) begin : g_param_check
        $error("perceptron_comm_ctrl: word width must be 16 and rx_timeout_cycles >= 1");
    end

    typedef enum logic [4:0] {
        IDLE         = 5'd0,
        RX_PAYLOAD   = 5'd1,
        COMMIT       = 5'd2,
        TX_LOAD      = 5'd3,
        TX_WAIT_BUSY = 5'd4,
        TX_WAIT_DONE = 5'd5
    } state_t;

    state_t      state, state_n;
    logic        rx_prev;
    logic        wr_inputs, wr_inputs_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [31:0] shadow, shadow_n;
    logic [55:0] resp, resp_n;
    logic [2:0]  tx_left, tx_left_n;
    logic        tx_start_n;
    logic [7:0]  tx_data_n;
    logic [15:0] weight1_n, weight2_n, input1_n, input2_n;
    logic        byte_take;
`ifdef COMM_RX_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(rx_timeout_cycles - 1);
    logic [31:0] tmo_cnt, tmo_cnt_n;
`endif

    assign byte_take  = rx_new_value & ~rx_prev;
    assign cont_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rx_prev   <= 1'b0;
            wr_inputs <= 1'b0;
            byte_cnt  <= '0;
            shadow    <= '0;
            resp      <= '0;
            tx_left   <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            weight1   <= '0;
            weight2   <= '0;
            input1    <= '0;
            input2    <= '0;
`ifdef COMM_RX_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            state     <= state_n;
            rx_prev   <= rx_new_value;
            wr_inputs <= wr_inputs_n;
            byte_cnt  <= byte_cnt_n;
            shadow    <= shadow_n;
            resp      <= resp_n;
            tx_left   <= tx_left_n;
            tx_start  <= tx_start_n;
            tx_data   <= tx_data_n;
            weight1   <= weight1_n;
            weight2   <= weight2_n;
            input1    <= input1_n;
            input2    <= input2_n;
`ifdef COMM_RX_TIMEOUT_EN
            tmo_cnt   <= tmo_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        wr_inputs_n = wr_inputs;
        byte_cnt_n  = byte_cnt;
        shadow_n    = shadow;
        resp_n      = resp;
        tx_left_n   = tx_left;
        tx_start_n  = tx_start;
        tx_data_n   = tx_data;
        weight1_n   = weight1;
        weight2_n   = weight2;
        input1_n    = input1;
        input2_n    = input2;
`ifdef COMM_RX_TIMEOUT_EN
        tmo_cnt_n   = tmo_cnt;
`endif
        case (state)
            IDLE: begin
                if (byte_take) begin
                    case (rx_data)
                        8'd5: begin
                            resp_n    = {8'd100, weight1, weight2, 8'h00, 7'b0, result};
                            tx_left_n = 3'd6;
                            state_n   = TX_LOAD;
                        end
                        8'd50, 8'd51: begin
                            wr_inputs_n = rx_data[0];
                            byte_cnt_n  = '0;
`ifdef COMM_RX_TIMEOUT_EN
                            tmo_cnt_n   = '0;
`endif
                            state_n     = RX_PAYLOAD;
                        end
                        default: begin
                            resp_n    = {8'd102, 48'h0};
                            tx_left_n = '0;
                            state_n   = TX_LOAD;
                        end
                    endcase
                end
            end
            RX_PAYLOAD: begin
                if (byte_take) begin
                    shadow_n   = {shadow[23:0], rx_data};
                    byte_cnt_n = byte_cnt + 2'd1;
`ifdef COMM_RX_TIMEOUT_EN
                    tmo_cnt_n  = '0;
`endif
                    if (byte_cnt == 2'd3) state_n = COMMIT;
                end
`ifdef COMM_RX_TIMEOUT_EN
                // Staged bytes are simply abandoned; the next write refills the shadow.
                else if (tmo_cnt == TMO_LAST) begin
                    resp_n    = {8'd102, 48'h0};
                    tx_left_n = '0;
                    state_n   = TX_LOAD;
                end else begin
                    tmo_cnt_n = tmo_cnt + 32'd1;
                end
`endif
            end
            COMMIT: begin
                if (wr_inputs) begin
                    input1_n = shadow[31:16];
                    input2_n = shadow[15:0];
                end else begin
                    weight1_n = shadow[31:16];
                    weight2_n = shadow[15:0];
                end
                resp_n    = {8'd101, 48'h0};
                tx_left_n = '0;
                state_n   = TX_LOAD;
            end
            TX_LOAD: begin
                tx_data_n  = resp[55:48];
                tx_start_n = 1'b1;
                state_n    = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (tx_busy) begin
                    tx_start_n = 1'b0;
                    state_n    = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (tx_left != 3'd0) begin
                        resp_n    = {resp[47:0], 8'h00};
                        tx_left_n = tx_left - 3'd1;
                        state_n   = TX_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
